ram_write_ctrl: RTL and testbench

//  Sequential writer for the 1024 x 64 on-chip memory that the rom_test read path consumes.

---
 rtl/ram_wr_pkg.sv | 14 +
 rtl/ram_write_ctrl.sv | 141 ++++++++++++++
 tb/tb_ram_write_ctrl.sv | 347 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ram_wr_pkg.sv
// Shared types and defaults for the sequential RAM write controller.
package ram_wr_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam int DEF_ADDR_W = 10;
    localparam int DEF_DATA_W = 64;
    localparam int MAX_LEN    = 2 ** DEF_ADDR_W;

endpackage

// File: rtl/ram_write_ctrl.sv
// Sequential writer: one registered RAM write per accepted stream beat at consecutive addresses.
// Optional RAM_WR_CHECKSUM_EN adds wr_csum, an XOR of every word written by the current command.
module ram_write_ctrl
    import ram_wr_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W,
    parameter int LEN_W  = ADDR_W + 1
) (
    input  logic              wr_clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] start_addr,
    input  logic [LEN_W-1:0]  wr_len,
    input  logic              abort,
    input  logic              s_valid,
    input  logic [DATA_W-1:0] s_data,
    output logic              s_ready,
    output logic              ram_wr_en,
    output logic [ADDR_W-1:0] ram_wr_addr,
    output logic [DATA_W-1:0] ram_wr_data,
    output logic              busy,
    output logic              done,
    output logic              err
`ifdef RAM_WR_CHECKSUM_EN
    ,
    output logic [DATA_W-1:0] wr_csum
`endif
);

    // One extra bit so a length of exactly 2**ADDR_W is representable in the compare.
    localparam logic [LEN_W:0] LEN_MAX = (LEN_W + 1)'(2 ** ADDR_W);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [LEN_W-1:0]  rem_q, rem_d;
    logic              wr_en_q, wr_en_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [DATA_W-1:0] wr_data_q, wr_data_d;
    logic              err_q, err_d;

    logic len_ok, load, reject, beat, last_beat;

    always_comb begin
        len_ok    = (wr_len != '0) && ({1'b0, wr_len} <= LEN_MAX);
        load      = (state_q == IDLE) && start && len_ok;
        reject    = (state_q == IDLE) && start && !len_ok;
        beat      = (state_q == WRITE) && s_valid && !abort;
        last_beat = beat && (rem_q == LEN_W'(1));
    end

    always_ff @(posedge wr_clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (load) state_d = WRITE;
            WRITE: begin
                if (abort)          state_d = IDLE;
                else if (last_beat) state_d = DONE;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        s_ready = (state_q == WRITE);
        busy    = (state_q != IDLE);
        done    = (state_q == DONE);
    end

    always_comb begin
        addr_d    = addr_q;
        rem_d     = rem_q;
        wr_en_d   = beat;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        err_d     = reject;
        if (load) begin
            addr_d = start_addr;
            rem_d  = wr_len;
        end else if (beat) begin
            addr_d    = addr_q + ADDR_W'(1);
            rem_d     = rem_q - LEN_W'(1);
            wr_addr_d = addr_q;
            wr_data_d = s_data;
        end
    end

    always_ff @(posedge wr_clk or posedge rst) begin
        if (rst) begin
            addr_q    <= '0;
            rem_q     <= '0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            err_q     <= 1'b0;
        end else begin
            addr_q    <= addr_d;
            rem_q     <= rem_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
            err_q     <= err_d;
        end
    end

    assign ram_wr_en   = wr_en_q;
    assign ram_wr_addr = wr_addr_q;
    assign ram_wr_data = wr_data_q;
    assign err         = err_q;

`ifdef RAM_WR_CHECKSUM_EN
    logic [DATA_W-1:0] csum_q, csum_d;

    // Accumulates on the beat edge so the sum lines up with that word's ram_wr_en.
    always_comb begin
        csum_d = csum_q;
        if (load)      csum_d = '0;
        else if (beat) csum_d = csum_q ^ s_data;
    end

    always_ff @(posedge wr_clk or posedge rst) begin
        if (rst) begin
            csum_q <= '0;
        end else begin
            csum_q <= csum_d;
        end
    end

    assign wr_csum = csum_q;
`endif

endmodule

// File: tb/tb_ram_write_ctrl.sv
// Self-checking bench for ram_write_ctrl: directed scenarios plus randomized commands
// checked every cycle against a command-level reference model.
module tb_ram_write_ctrl;

    localparam int AW    = 10;
    localparam int DW    = 64;
    localparam int LW    = 11;
    localparam int DEPTH = 1024;

    logic          wr_clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic [AW-1:0] start_addr = '0;
    logic [LW-1:0] wr_len = '0;
    logic          abort = 1'b0;
    logic          s_valid = 1'b0;
    logic [DW-1:0] s_data = '0;
    logic          s_ready, ram_wr_en, busy, done, err;
    logic [AW-1:0] ram_wr_addr;
    logic [DW-1:0] ram_wr_data;
`ifdef RAM_WR_CHECKSUM_EN
    logic [DW-1:0] wr_csum;
`endif

    ram_write_ctrl dut (
        .wr_clk      (wr_clk),
        .rst         (rst),
        .start       (start),
        .start_addr  (start_addr),
        .wr_len      (wr_len),
        .abort       (abort),
        .s_valid     (s_valid),
        .s_data      (s_data),
        .s_ready     (s_ready),
        .ram_wr_en   (ram_wr_en),
        .ram_wr_addr (ram_wr_addr),
        .ram_wr_data (ram_wr_data),
        .busy        (busy),
        .done        (done),
        .err         (err)
`ifdef RAM_WR_CHECKSUM_EN
        ,
        .wr_csum     (wr_csum)
`endif
    );

    always #5 wr_clk = ~wr_clk;

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    // Reference model: a command is a count of words still owed and the next address;
    // the finishing cycle after the last word is tracked as a flag.
    int            m_rem;
    int            m_addr;
    bit            m_fin;
    logic          e_wr_en, e_busy, e_done, e_err, e_ready;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_data, e_csum;
    int            log_addr[$];
    logic [DW-1:0] log_data[$];
    int            n_done, n_done_wr, n_err, n_busy;

    always @(posedge wr_clk or posedge rst) begin
        if (rst) begin
            m_rem = 0; m_addr = 0; m_fin = 0;
            e_wr_en = 0; e_busy = 0; e_done = 0; e_err = 0; e_ready = 0;
            e_addr = '0; e_data = '0; e_csum = '0;
        end else begin
            e_wr_en = 0;
            e_err   = 0;
            if (m_fin) begin
                m_fin = 0;
            end else if (m_rem > 0) begin
                if (abort) begin
                    m_rem = 0;
                end else if (s_valid) begin
                    e_wr_en = 1;
                    e_addr  = AW'(m_addr);
                    e_data  = s_data;
                    e_csum  = e_csum ^ s_data;
                    log_addr.push_back(m_addr);
                    log_data.push_back(s_data);
                    m_addr = (m_addr + 1) % DEPTH;
                    m_rem  = m_rem - 1;
                    if (m_rem == 0) m_fin = 1;
                end
            end else if (start) begin
                if (wr_len == 0 || int'(wr_len) > DEPTH) begin
                    e_err = 1;
                end else begin
                    m_addr = int'(start_addr);
                    m_rem  = int'(wr_len);
                    e_csum = '0;
                end
            end
            e_busy  = (m_rem > 0) || m_fin;
            e_done  = m_fin;
            e_ready = (m_rem > 0);
            if (e_done) n_done++;
            if (e_done && e_wr_en) n_done_wr++;
            if (e_err) n_err++;
            if (e_busy) n_busy++;
        end
    end

    always @(negedge wr_clk) begin
        if (!rst) begin
            chk("ram_wr_en", ram_wr_en, e_wr_en);
            chk("ram_wr_addr", ram_wr_addr, e_addr);
            chk("ram_wr_data", ram_wr_data, e_data);
            chk("busy", busy, e_busy);
            chk("done", done, e_done);
            chk("err", err, e_err);
            chk("s_ready", s_ready, e_ready);
`ifdef RAM_WR_CHECKSUM_EN
            chk("wr_csum", wr_csum, e_csum);
`endif
        end
    end

    logic [DW-1:0] fixed_data[16];
    bit            use_fixed = 0;

    task automatic clear_log();
        log_addr.delete();
        log_data.delete();
        n_done = 0; n_done_wr = 0; n_err = 0; n_busy = 0;
    endtask

    task automatic send_cmd(input int a, input int l);
        start      = 1'b1;
        start_addr = AW'(a);
        wr_len     = LW'(l);
        @(negedge wr_clk);
        start = 1'b0;
    endtask

    // vmode: 0 back-to-back, 1 alternating valid, 2 random valid.
    task automatic do_stream(input int n, input int vmode, input int abort_at, input bit noise);
        int  acc = 0;
        int  cyc = 0;
        bit  tog = 1'b1;
        bit  acc_now;
        while (acc < n && cyc < 5000) begin
            s_valid = (vmode == 0) ? 1'b1 : (vmode == 1) ? tog : ($urandom_range(0, 3) != 0);
            tog     = ~tog;
            s_data  = use_fixed ? fixed_data[acc] : {$urandom, $urandom};
            abort   = (abort_at >= 0) && (acc == abort_at);
            start   = noise && ((cyc == 3) || ($urandom_range(0, 7) == 0));
            if (start) begin
                start_addr = AW'($urandom);
                wr_len     = LW'($urandom_range(1, 20));
            end
            acc_now = s_valid && s_ready && !abort;
            @(negedge wr_clk);
            cyc++;
            if (acc_now) acc++;
            if (abort) break;
        end
        if (cyc >= 5000) begin
            checks++; failures++;
            $display("FAIL stream_timeout accepted=%0d required=%0d", acc, n);
        end
        s_valid = 1'b0;
        abort   = 1'b0;
        start   = 1'b0;
    endtask

    task automatic wait_idle();
        int k = 0;
        while ((m_rem > 0 || m_fin) && k < 3000) begin
            @(negedge wr_clk);
            k++;
        end
        if (k >= 3000) begin
            checks++; failures++;
            $display("FAIL idle_timeout cycles=%0d required=<3000", k);
        end
        @(negedge wr_clk);
    endtask

    initial begin
        #900000;
        $display("FAIL global_timeout time=%0t", $time);
        $fatal(1, "bench timeout");
    end

    initial begin
        int a, l, ab;
        rst = 1'b1;
        repeat (2) @(negedge wr_clk);
        chk("rst_wr_en", ram_wr_en, 0);
        chk("rst_addr", ram_wr_addr, 0);
        chk("rst_data", ram_wr_data, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        chk("rst_ready", s_ready, 0);
`ifdef RAM_WR_CHECKSUM_EN
        chk("rst_csum", wr_csum, 0);
`endif
        rst = 1'b0;
        @(negedge wr_clk);

        // Four words back to back from address 0
        clear_log();
        for (int i = 0; i < 4; i++) fixed_data[i] = 64'hA0 + 64'(i);
        use_fixed = 1;
        send_cmd(0, 4);
        do_stream(4, 0, -1, 0);
        use_fixed = 0;
        wait_idle();
        chk("t1_count", log_addr.size(), 4);
        for (int i = 0; i < 4; i++) begin
            chk("t1_addr", log_addr[i], i);
            chk("t1_data", log_data[i], 64'hA0 + 64'(i));
        end
        chk("t1_done", n_done, 1);
        chk("t1_done_with_write", n_done_wr, 1);

        // Address wrap at the top of memory
        clear_log();
        send_cmd(12'h3FE, 4);
        do_stream(4, 0, -1, 0);
        wait_idle();
        chk("t2_count", log_addr.size(), 4);
        chk("t2_a0", log_addr[0], 12'h3FE);
        chk("t2_a1", log_addr[1], 12'h3FF);
        chk("t2_a2", log_addr[2], 0);
        chk("t2_a3", log_addr[3], 1);
        chk("t2_done", n_done, 1);

        // Illegal lengths
        clear_log();
        send_cmd(0, 0);
        @(negedge wr_clk);
        chk("t3_err_len0", n_err, 1);
        send_cmd(5, 1025);
        @(negedge wr_clk);
        chk("t3_err_len1025", n_err, 2);
        chk("t3_no_writes", log_addr.size(), 0);
        chk("t3_never_busy", n_busy, 0);

        // Gapped stream with a start pulse during the command
        clear_log();
        send_cmd(12'h100, 8);
        do_stream(8, 1, -1, 1);
        wait_idle();
        chk("t4_count", log_addr.size(), 8);
        for (int i = 0; i < 8; i++) chk("t4_addr", log_addr[i], 12'h100 + i);
        chk("t4_done", n_done, 1);
        chk("t4_err", n_err, 0);

        // Abort after three beats with valid high in the abort cycle
        clear_log();
        send_cmd(12'h200, 8);
        do_stream(8, 0, 3, 0);
        chk("t5_idle_after_abort", busy, 0);
        chk("t5_count", log_addr.size(), 3);
        @(negedge wr_clk);
        chk("t5_no_done", n_done, 0);
        clear_log();
        send_cmd(12'h050, 2);
        do_stream(2, 0, -1, 0);
        wait_idle();
        chk("t5_restart_count", log_addr.size(), 2);
        chk("t5_restart_a0", log_addr[0], 12'h050);
        chk("t5_restart_a1", log_addr[1], 12'h051);
        chk("t5_restart_done", n_done, 1);

`ifdef RAM_WR_CHECKSUM_EN
        // Checksum over three words, then cleared by the next command
        clear_log();
        fixed_data[0] = 64'h1; fixed_data[1] = 64'h2; fixed_data[2] = 64'h4;
        use_fixed = 1;
        send_cmd(0, 3);
        do_stream(3, 0, -1, 0);
        use_fixed = 0;
        chk("t6_done_now", done, 1);
        chk("t6_csum_at_done", wr_csum, 64'h7);
        chk("t6_model_csum", e_csum, 64'h7);
        wait_idle();
        send_cmd(5, 2);
        chk("t6_csum_cleared", wr_csum, 0);
        do_stream(2, 0, -1, 0);
        wait_idle();
`endif

        // Full-depth command starting at the last address
        clear_log();
        send_cmd(12'h3FF, 1024);
        do_stream(1024, 0, -1, 0);
        wait_idle();
        chk("full_count", log_addr.size(), 1024);
        chk("full_first", log_addr[0], 12'h3FF);
        chk("full_last", log_addr[1023], 12'h3FE);
        chk("full_done", n_done, 1);

        // Reset in the middle of a command
        send_cmd(12'h010, 8);
        do_stream(2, 0, -1, 0);
        rst = 1'b1;
        #1;
        chk("midrst_busy", busy, 0);
        chk("midrst_ready", s_ready, 0);
        chk("midrst_wr_en", ram_wr_en, 0);
        chk("midrst_addr", ram_wr_addr, 0);
        @(negedge wr_clk);
        rst = 1'b0;
        @(negedge wr_clk);

        // Randomized commands
        for (int it = 0; it < 40; it++) begin
            clear_log();
            a = int'($urandom_range(0, DEPTH - 1));
            if ($urandom_range(0, 7) == 0) begin
                l = ($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(1025, 2047));
                send_cmd(a, l);
                @(negedge wr_clk);
                chk("rnd_err", n_err, 1);
                chk("rnd_err_nowrite", log_addr.size(), 0);
            end else begin
                l  = int'($urandom_range(1, 48));
                ab = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, l - 1)) : -1;
                send_cmd(a, l);
                do_stream(l, 2, ab, 1);
                wait_idle();
                chk("rnd_count", log_addr.size(), (ab < 0) ? l : ab);
                chk("rnd_done", n_done, (ab < 0) ? 1 : 0);
                if (log_addr.size() > 0) chk("rnd_first_addr", log_addr[0], a);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
